// File: rtl/module_hamming_encoder.sv
// Hamming(7,4) encoder with a one-entry valid/ready output register,
// optional single-bit error injection and delivery counters.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_data/valid/ready  4-bit data word handshake
//   err_pos              0 = clean, 1..7 = flip codeword bit [err_pos-1]
//   out_word/valid/ready 7-bit codeword handshake
//   out_flip             err_pos value applied to out_word
//   cnt_clr              sync clear of both counters
//   cw_count, err_count  delivered words / delivered corrupted words
module module_hamming_encoder #(
  parameter int CNT_W     = 16,
  parameter bit INJECT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       err_pos,
  output logic [6:0]       out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_flip,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cw_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [6:0]       out_word_q, out_word_d;
  logic [2:0]       out_flip_q, out_flip_d;
  logic [CNT_W-1:0] cw_count_q, cw_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic       capture;
  logic       deliver;
  logic [6:0] enc;
  logic [6:0] mask;
  logic [2:0] flip_sel;

  assign out_valid = (state_q == FULL);
  // Never depends on in_valid: only state and downstream ready.
  assign in_ready  = (state_q == EMPTY) || out_ready;

  assign capture = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // Bit [k] sits at 1-based position k+1, so a syndrome
  // names the failing bit directly.
  assign enc[2] = in_data[0];
  assign enc[4] = in_data[1];
  assign enc[5] = in_data[2];
  assign enc[6] = in_data[3];
  assign enc[0] = in_data[0] ^ in_data[1] ^ in_data[3];
  assign enc[1] = in_data[0] ^ in_data[2] ^ in_data[3];
  assign enc[3] = in_data[1] ^ in_data[2] ^ in_data[3];

  assign flip_sel = INJECT_EN ? err_pos : 3'd0;

  always_comb begin
    mask = 7'd0;
    if (flip_sel != 3'd0) begin
      mask = 7'd1 << (flip_sel - 3'd1);
    end
  end

  always_comb begin
    state_d    = state_q;
    out_word_d = out_word_q;
    out_flip_d = out_flip_q;
    if (capture) begin
      state_d    = FULL;
      out_word_d = enc ^ mask;
      out_flip_d = flip_sel;
    end else if (deliver) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    cw_count_d  = cw_count_q;
    err_count_d = err_count_q;
    if (cnt_clr) begin
      cw_count_d  = '0;
      err_count_d = '0;
    end else if (deliver) begin
      cw_count_d = cw_count_q + CNT_W'(1);
      if (out_flip_q != 3'd0) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_word_q  <= 7'd0;
      out_flip_q  <= 3'd0;
      cw_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_word_q  <= out_word_d;
      out_flip_q  <= out_flip_d;
      cw_count_q  <= cw_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_flip  = out_flip_q;
  assign cw_count  = cw_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_module_hamming_encoder.sv
// Scoreboard bench for module_hamming_encoder.
// Counters run at a reduced width so the wrap point is reachable.
module tb_module_hamming_encoder;

  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    err_pos;
  logic [6:0]    out_word;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_flip;
  logic          cnt_clr;
  logic [CW-1:0] cw_count;
  logic [CW-1:0] err_count;

  module_hamming_encoder #(
    .CNT_W    (CW),
    .INJECT_EN(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .err_pos  (err_pos),
    .out_word (out_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_flip (out_flip),
    .cnt_clr  (cnt_clr),
    .cw_count (cw_count),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] flip;
    logic [6:0] word;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_cw  = '0;
  logic [CW-1:0] exp_err = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Codeword as XOR of per-bit basis codewords.
  function automatic logic [6:0] model(input logic [3:0] d,
                                       input logic [2:0] ep);
    logic [6:0] w;
    w = 7'd0;
    if (d[0]) w = w ^ 7'b0000111;
    if (d[1]) w = w ^ 7'b0011001;
    if (d[2]) w = w ^ 7'b0101010;
    if (d[3]) w = w ^ 7'b1001011;
    if (ep != 3'd0) w[ep-3'd1] = ~w[ep-3'd1];
    return w;
  endfunction

  function automatic logic [3:0] correct(input logic [6:0] w);
    logic [2:0] s;
    logic [6:0] c;
    s[0] = w[0] ^ w[2] ^ w[4] ^ w[6];
    s[1] = w[1] ^ w[2] ^ w[5] ^ w[6];
    s[2] = w[3] ^ w[4] ^ w[5] ^ w[6];
    c = w;
    if (s != 3'd0) c[s-3'd1] = ~c[s-3'd1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Monitor: compare every delivered word against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none",
                 out_word);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_word", out_word, e.word);
        chk("out_flip", out_flip, e.flip);
        chk("corrected", correct(out_word), e.data);
      end
    end
  end

  // Holds in_valid high on return so calls chain back-to-back.
  task automatic send(input logic [3:0] d, input logic [2:0] ep,
                      input logic [6:0] w);
    int n;
    exp_t e;
    in_data  = d;
    err_pos  = ep;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    e.data = d;
    e.flip = ep;
    e.word = w;
    sb_q.push_back(e);
    exp_cw = exp_cw + 1'b1;
    if (ep != 3'd0) exp_err = exp_err + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0 || out_valid) chk("drain_timeout", 1, 0);
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_cw"}, cw_count, exp_cw);
    chk({nm, "_err"}, err_count, exp_err);
  endtask

  logic [6:0] wa;

  initial begin
    rst_n     = 1'b0;
    in_data   = 4'b1011;
    in_valid  = 1'b1;
    err_pos   = 3'd0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    // Reset with in_valid high.
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_word", out_word, 0);
      chk("rst_flip", out_flip, 0);
      chk("rst_cw", cw_count, 0);
      chk("rst_err", err_count, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic word and one-cycle latency.
    send(4'b1011, 3'd0, 7'b1010101);
    in_valid = 1'b0;
    chk("lat_valid", out_valid, 1);
    @(posedge clk);
    #1;
    chk("first_cw", cw_count, 1);

    // Spot checks and injection.
    send(4'b0000, 3'd0, 7'b0000000);
    send(4'b1111, 3'd0, 7'b1111111);
    send(4'b0001, 3'd0, 7'b0000111);
    send(4'b1011, 3'd5, 7'b1000101);
    drain();
    chk_cnt("directed");

    // Full sweep, back-to-back.
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        send(4'(d), 3'(p), model(4'(d), 3'(p)));
      end
    end
    drain();
    chk_cnt("sweep");

    // Backpressure: B must wait while A is held.
    out_ready = 1'b0;
    wa = model(4'b0110, 3'd2);
    send(4'b0110, 3'd2, wa);
    fork
      begin
        send(4'b1001, 3'd0, model(4'b1001, 3'd0));
        send(4'b0011, 3'd7, model(4'b0011, 3'd7));
        in_valid = 1'b0;
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold_word", out_word, wa);
          chk("bp_hold_flip", out_flip, 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk_cnt("backpressure");

    // Clear wins over a same-cycle delivery.
    send(4'b0101, 3'd1, model(4'b0101, 3'd1));
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    exp_cw  = '0;
    exp_err = '0;
    chk_cnt("clr_vs_deliver");
    drain();

    // Wrap at 2^CW-1.
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      send(4'(i % 16), 3'(1 + i % 7), model(4'(i % 16), 3'(1 + i % 7)));
    end
    drain();
    chk("near_max_cw", cw_count, (1 << CW) - 1);
    chk("near_max_err", err_count, (1 << CW) - 1);
    send(4'b1100, 3'd3, model(4'b1100, 3'd3));
    drain();
    chk("wrap_cw", cw_count, 0);
    chk("wrap_err", err_count, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
